// File: rtl/cpu_pkg.sv
// Definitions shared between the decoder and the load/store unit:
// funct3 width codes, memory opcodes and the LSU state encoding.
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for RV32I loads/stores: legality, alignment, byte
// enables, store-data replication and load extraction/extension.
module lsu_align
  import cpu_pkg::*;
(
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        legal_o,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    if (store_i) begin
      legal_o = (funct3_i == F3_SB) || (funct3_i == F3_SH) || (funct3_i == F3_SW);
    end else begin
      legal_o = (funct3_i == F3_LB) || (funct3_i == F3_LH) || (funct3_i == F3_LW) ||
                (funct3_i == F3_LBU) || (funct3_i == F3_LHU);
    end
  end

  // funct3[1:0] encodes access size for both loads and stores
  always_comb begin
    aligned_o = 1'b1;
    be_o      = '0;
    wdata_o   = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        aligned_o = ~addr_i[0];
        be_o      = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        aligned_o = (addr_i == 2'b00);
        be_o      = 4'b1111;
      end
      default: begin
        aligned_o = 1'b1;
        be_o      = '0;
      end
    endcase
  end

  always_comb begin
    shifted = rdata_i >> {addr_i, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   rdata_o = {{24{lane_b[7]}}, lane_b};
      F3_LH:   rdata_o = {{16{lane_h[15]}}, lane_h};
      F3_LW:   rdata_o = rdata_i;
      F3_LBU:  rdata_o = {24'h0, lane_b};
      F3_LHU:  rdata_o = {16'h0, lane_h};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-access stage: accepts one load/store, drives a req/ack data-memory
// port with a bounded wait, and returns the extended result or an error.
module lsu
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [CW-1:0] cnt_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        mem_we_q;
  logic [29:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic        idle;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_alo;
  logic        al_legal;
  logic        al_aligned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  // One steering block serves both phases: live request fields while idle
  // (checks, enables, write data), latched fields afterwards (load extraction).
  assign idle     = (state_q == LSU_IDLE);
  assign al_store = idle ? req_store       : store_q;
  assign al_f3    = idle ? req_funct3      : f3_q;
  assign al_alo   = idle ? req_addr[1:0]   : alo_q;

  lsu_align u_align (
    .store_i   (al_store),
    .funct3_i  (al_f3),
    .addr_i    (al_alo),
    .wdata_i   (req_wdata),
    .rdata_i   (mem_rdata),
    .legal_o   (al_legal),
    .aligned_o (al_aligned),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      store_q     <= 1'b0;
      f3_q        <= '0;
      alo_q       <= '0;
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            f3_q    <= req_funct3;
            alo_q   <= req_addr[1:0];
            cnt_q   <= '0;
            if (al_legal && al_aligned) begin
              state_q     <= LSU_ACCESS;
              mem_we_q    <= req_store;
              mem_addr_q  <= req_addr[31:2];
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end else begin
              state_q     <= LSU_RESP;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        LSU_ACCESS: begin
          // ack wins over timeout in the final waiting cycle
          if (mem_ack) begin
            state_q     <= LSU_RESP;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= store_q ? '0 : al_rdata;
            mem_we_q    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= LSU_RESP;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LSU_RESP: begin
          state_q     <= LSU_IDLE;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == LSU_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = (state_q == LSU_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-addressed memory
// model and RV32I load/store semantics.
module tb_lsu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem_b [64];

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [31:0] w;
    int unsigned base;
    base = {26'd0, addr[5:2], 2'b00};
    for (int n = 0; n < 4; n++) w[8*n +: 8] = mem_b[base + n];
    return w;
  endfunction

  task automatic poke_word(input logic [31:0] addr, input logic [31:0] w);
    int unsigned base;
    base = {26'd0, addr[5:2], 2'b00};
    for (int n = 0; n < 4; n++) mem_b[base + n] = w[8*n +: 8];
  endtask

  // ack_at: ACCESS cycle (1-based) in which memory acks; 0 = never
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_at);
    int unsigned size;
    bit ok, acked, timed_out;
    logic [31:0] exp_be, exp_wd, exp_rd, v;
    int unsigned off;
    size = 32'd1 << f3[1:0];
    ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ok = ok && ((addr % size) == 0);
    exp_be = ((32'd1 << size) - 1) << addr[1:0];
    for (int n = 0; n < 4; n++) exp_wd[8*n +: 8] = wd[8*(n % size) +: 8];

    @(negedge clk);
    check_eq("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_store = $urandom; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    if (!ok) begin
      check_eq("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("err_rsp_err", {31'd0, rsp_err}, 32'd1);
      check_eq("err_rsp_rdata", rsp_rdata, 32'd0);
      check_eq("err_no_mem_req", {31'd0, mem_req}, 32'd0);
    end else begin
      acked = 0; timed_out = 0;
      for (int c = 1; c <= int'(TMO); c++) begin
        check_eq("mem_req", {31'd0, mem_req}, 32'd1);
        check_eq("rsp_valid_busy", {31'd0, rsp_valid}, 32'd0);
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, st});
        check_eq("mem_addr", {2'b00, mem_addr}, {2'b00, addr[31:2]});
        check_eq("mem_be", {28'd0, mem_be}, exp_be);
        if (st) check_eq("mem_wdata", mem_wdata, exp_wd);
        if (c == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = model_word(addr);
          acked = 1;
          if (st) begin
            for (int n = 0; n < 4; n++)
              if (mem_be[n]) mem_b[{26'd0, addr[5:2], 2'b00} + n] = mem_wdata[8*n +: 8];
          end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (acked) break;
        if (c == int'(TMO)) timed_out = 1;
      end
      exp_rd = 32'd0;
      if (!st && acked) begin
        v = 32'd0;
        off = {26'd0, addr[5:0]};
        for (int i = 0; i < int'(size); i++) v = v | ({24'd0, mem_b[(off + i) % 64]} << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
        exp_rd = v;
      end
      check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, timed_out});
      check_eq("rsp_rdata", rsp_rdata, exp_rd);
      check_eq("mem_req_resp", {31'd0, mem_req}, 32'd0);
      check_eq("ready_resp", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    check_eq("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    check_eq("ready_after", {31'd0, req_ready}, 32'd1);
    check_eq("mem_req_after", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    #1;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check_eq("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // SW with one-cycle ack; word lands in model memory
    run_op(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1);
    check_eq("sw_stored", model_word(32'h0000_1004), 32'hDEAD_BEEF);
    // SB to lane 3, then LB/LBU of a negative byte
    run_op(1'b1, 3'b000, 32'h0000_0023, 32'h0000_00A5, 2);
    check_eq("sb_stored", {24'd0, mem_b[35]}, 32'h0000_00A5);
    poke_word(32'h20, 32'h8000_0000);
    run_op(1'b0, 3'b000, 32'h0000_0023, 32'h0, 1);
    run_op(1'b0, 3'b100, 32'h0000_0023, 32'h0, 3);
    poke_word(32'h30, 32'h8001_1234);
    run_op(1'b0, 3'b001, 32'h0000_0032, 32'h0, 1);
    run_op(1'b0, 3'b101, 32'h0000_0032, 32'h0, 1);
    run_op(1'b0, 3'b001, 32'h0000_0031, 32'h0, 1);
    run_op(1'b0, 3'b011, 32'h0000_0030, 32'h0, 1);
    run_op(1'b1, 3'b100, 32'h0000_0030, 32'h0, 1);
    // timeout, then ack in the last allowed cycle
    run_op(1'b0, 3'b010, 32'h0000_0010, 32'h0, 0);
    run_op(1'b0, 3'b010, 32'h0000_0010, 32'h0, int'(TMO));

    // reset in the middle of an access
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    @(negedge clk); req_valid = 1'b0;
    check_eq("mid_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("async_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("async_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    run_op(1'b0, 3'b010, 32'h0000_0008, 32'h0, 2);

    for (int k = 0; k < 300; k++) begin
      run_op(1'($urandom), 3'($urandom), {$urandom_range(0, 15), 22'($urandom), 6'($urandom)},
             $urandom, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit forming the memory-access stage directly downstream of the execute stage's ALU. It accepts one RV32I load or store per request, using the ALU-computed effective address, `funct3` and the store data from `rs2`. It steers bytes onto a 32-bit word-addressed data-memory port with a req/ack handshake, then returns a sign- or zero-extended load result (or a store completion) for register writeback. Misaligned or illegal accesses and memory timeouts are reported as errors without corrupting memory.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack` before aborting; minimum 1.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  32  byte effective address (ALU result).
- `req_wdata`  in  32  store data (rs2).
- `rsp_valid`  out  1  single-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  valid with `rsp_valid`; misaligned, illegal or timeout.
- `mem_req`  out  1  memory request, held until `mem_ack` or timeout.
- `mem_we`  out  1  write strobe qualifier.
- `mem_addr`  out  30  word address = `req_addr[31:2]`.
- `mem_be`  out  4  byte enables, bit n = byte lane n (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completed the current request this cycle.
- `mem_rdata`  in  32  read word, valid when `mem_ack`=1.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields. If legal and aligned, go to ACCESS; otherwise go to RESP with err=1 and issue no memory access.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code is illegal and raises err.
- Alignment: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0. Byte accesses are always aligned.
- Byte enables: byte `0001<<addr[1:0]`; half `0011` (addr[1]=0) or `1100`; word `1111`. Loads drive the same `mem_be`.
- Store data: byte replicated ×4; half replicated ×2; word unchanged.
- Load extraction: select lane(s) by `addr[1:0]`; LB/LH sign-extend, LBU/LHU zero-extend.
- ACCESS: `mem_req`=1 with `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` stable every cycle. On `mem_ack`, capture `mem_rdata` (loads) and go to RESP.
- ACCESS timeout: a cycle counter starts at 0 on entry and increments each cycle without ack. If ack has not arrived when the counter reaches `TIMEOUT`−1, go to RESP with err=1. The `mem_ack` check takes priority in that final cycle.
- RESP: `rsp_valid`=1 for one cycle, then go to IDLE.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, counter 0.
- All outputs are registered or decoded from state; no combinational path from `mem_ack`/`mem_rdata` to any output.
- Accept in cycle T. `mem_req` is high from T+1. Ack in cycle T+k (k≥1) gives `rsp_valid` in T+k+1 and `req_ready` in T+k+2.
- Minimum latency is 2 cycles from accept to response; maximum throughput is one access per 3 cycles.
- Error at accept: `rsp_valid` with err at T+1; `mem_req` never asserts.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, drops with the transition to RESP.
- Reset asserted mid-ACCESS: `mem_req` and every other output drop immediately, asynchronously; the pending access is discarded with no response.

## Structure
- Shared package `cpu_pkg`: funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW), LSU state enum, load/store opcode constants shared with the decoder.
- One combinational sub-module, `lsu_align`: given funct3 and `addr[1:0]`, produces legal/aligned flags, `mem_be`, replicated write data, and load extraction/extension. The top level holds the FSM, registers and timeout counter.

## Test plan
- SW addr 0x0000_1004, data 0xDEADBEEF, ack after 1 cycle -> `mem_addr`=0x401, be=1111, wdata=0xDEADBEEF, `rsp_valid` 2 cycles after accept, err=0.
- SB addr 0x...03, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5; LB at the same address with rdata 0x80000000 -> 0xFFFFFF80; LBU -> 0x00000080.
- LH addr 0x...02, rdata 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; LH addr 0x...01 -> err=1 at T+1, `mem_req` never high.
- Illegal funct3 011 load, and store funct3 100 -> err=1, no memory access.
- `TIMEOUT`=4, no ack -> `mem_req` high exactly 4 cycles, then `rsp_valid`+err; ack arriving in the 4th cycle -> normal completion with err=0.
- Assert `rst` during ACCESS -> `mem_req` low in the same cycle, no `rsp_valid`, `req_ready`=1 after release; a following LW completes normally.
